// File: rtl/bsg_axi_burst_master_pkg.sv
// bsg_axi_burst_master_pkg: shared FSM states and AXI response/burst encodings
package bsg_axi_burst_master_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_e;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] INCR   = 2'b01;
  function automatic logic resp_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction
endpackage

// File: rtl/bsg_axi_burst_master_if.sv
// bsg_axi_burst_master_if: single-ID AXI4 bus between the burst master and a memory slave
interface bsg_axi_burst_master_if #(
  parameter int axi_id_width_p   = 4,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32,
  parameter int axi_len_width_p  = 8
) ();
  localparam int axi_strb_width_lp = axi_data_width_p >> 3;
  logic [axi_id_width_p-1:0]    awid;
  logic [axi_addr_width_p-1:0]  awaddr;
  logic [axi_len_width_p-1:0]   awlen;
  logic [1:0]                   awburst;
  logic                         awvalid, awready;
  logic [axi_data_width_p-1:0]  wdata;
  logic [axi_strb_width_lp-1:0] wstrb;
  logic                         wlast, wvalid, wready;
  logic [axi_id_width_p-1:0]    bid;
  logic [1:0]                   bresp;
  logic                         bvalid, bready;
  logic [axi_id_width_p-1:0]    arid;
  logic [axi_addr_width_p-1:0]  araddr;
  logic [axi_len_width_p-1:0]   arlen;
  logic [1:0]                   arburst;
  logic                         arvalid, arready;
  logic [axi_id_width_p-1:0]    rid;
  logic [axi_data_width_p-1:0]  rdata;
  logic [1:0]                   rresp;
  logic                         rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/bsg_axi_beat_counter.sv
// bsg_axi_beat_counter: clearable beat counter flagging the final beat of a burst
module bsg_axi_beat_counter #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic [width_p-1:0] len_i,
  output logic               last_o
);
  logic [width_p-1:0] r_cnt;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_cnt <= '0;
    else if (clear_i) r_cnt <= '0;
    else if (up_i) r_cnt <= r_cnt + 1'b1;
  assign last_o = r_cnt == len_i;
endmodule

// File: rtl/bsg_axi_burst_master.sv
// bsg_axi_burst_master: turns command/stream transfers into one-at-a-time AXI4 INCR bursts
module bsg_axi_burst_master
  import bsg_axi_burst_master_pkg::*;
#(
  parameter int axi_id_width_p   = 4,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32,
  parameter int axi_len_width_p  = 8,
  parameter logic [axi_id_width_p-1:0] axi_id_p = '0,
  localparam int axi_strb_width_lp = axi_data_width_p >> 3,
  localparam int lg_beat_bytes_lp  = $clog2(axi_strb_width_lp)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cmd_v_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_write_i,
  input  logic [axi_addr_width_p-1:0]  cmd_addr_i,
  input  logic [axi_len_width_p-1:0]   cmd_len_i,
  input  logic [axi_data_width_p-1:0]  wdata_i,
  input  logic [axi_strb_width_lp-1:0] wstrb_i,
  input  logic                         wdata_v_i,
  output logic                         wdata_ready_o,
  output logic [axi_data_width_p-1:0]  rdata_o,
  output logic                         rdata_last_o,
  output logic                         rdata_v_o,
  input  logic                         rdata_ready_i,
  output logic                         done_v_o,
  output logic                         done_err_o,
  input  logic                         done_ready_i,
  bsg_axi_burst_master_if.master       axi
);
  localparam logic [axi_addr_width_p-1:0] addr_mask_lp = {axi_addr_width_p{1'b1}} << lg_beat_bytes_lp;
  state_e                        r_state;
  logic [axi_addr_width_p-1:0]   r_addr;
  logic [axi_len_width_p-1:0]    r_len;
  logic                          r_err;
  logic                          w_last, w_w_hs, w_r_hs;
  assign w_w_hs = r_state == WR_DATA && wdata_v_i && axi.wready;
  assign w_r_hs = r_state == RD_DATA && axi.rvalid && rdata_ready_i;
  bsg_axi_beat_counter #(.width_p(axi_len_width_p)) beat_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cmd_v_i && cmd_ready_o),
    .up_i      (w_w_hs || w_r_hs),
    .len_i     (r_len),
    .last_o    (w_last)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else
      case (r_state)
        IDLE: if (cmd_v_i) begin
          r_addr  <= cmd_addr_i & addr_mask_lp;
          r_len   <= cmd_len_i;
          r_err   <= 1'b0;
          r_state <= cmd_write_i ? WR_ADDR : RD_ADDR;
        end
        WR_ADDR: if (axi.awready) r_state <= WR_DATA;
        WR_DATA: if (w_w_hs && w_last) r_state <= WR_RESP;
        WR_RESP: if (axi.bvalid) begin
          r_err   <= r_err | resp_err(axi.bresp);
          r_state <= DONE;
        end
        RD_ADDR: if (axi.arready) r_state <= RD_DATA;
        // rlast must coincide with the counted final beat; any disagreement is an error
        RD_DATA: if (w_r_hs) begin
          r_err <= r_err | resp_err(axi.rresp) | (axi.rlast != w_last);
          if (w_last) r_state <= DONE;
        end
        DONE: if (done_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
  assign cmd_ready_o   = reset_n_i && r_state == IDLE;
  assign wdata_ready_o = r_state == WR_DATA && axi.wready;
  assign rdata_o       = axi.rdata;
  assign rdata_last_o  = axi.rlast;
  assign rdata_v_o     = r_state == RD_DATA && axi.rvalid;
  assign done_v_o      = r_state == DONE;
  assign done_err_o    = r_state == DONE && r_err;
  assign axi.awid      = axi_id_p;
  assign axi.awaddr    = r_addr;
  assign axi.awlen     = r_len;
  assign axi.awburst   = INCR;
  assign axi.awvalid   = r_state == WR_ADDR;
  assign axi.wdata     = wdata_i;
  assign axi.wstrb     = wstrb_i;
  assign axi.wlast     = w_last;
  assign axi.wvalid    = r_state == WR_DATA && wdata_v_i;
  assign axi.bready    = r_state == WR_RESP;
  assign axi.arid      = axi_id_p;
  assign axi.araddr    = r_addr;
  assign axi.arlen     = r_len;
  assign axi.arburst   = INCR;
  assign axi.arvalid   = r_state == RD_ADDR;
  assign axi.rready    = r_state == RD_DATA && rdata_ready_i;
endmodule

// File: tb/tb_bsg_axi_burst_master.sv
// tb_bsg_axi_burst_master: directed transfers against a memory slave model with queue scoreboard
module tb_bsg_axi_burst_master;
  import bsg_axi_burst_master_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic        cmd_v_i = 0, cmd_write_i = 0, cmd_ready_o;
  logic [31:0] cmd_addr_i = 0;
  logic [7:0]  cmd_len_i = 0;
  logic [31:0] wdata_i = 0;
  logic [3:0]  wstrb_i = 4'hF;
  logic        wdata_v_i = 0, wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_last_o, rdata_v_o, rdata_ready_i = 1;
  logic        done_v_o, done_err_o, done_ready_i = 1;
  bsg_axi_burst_master_if #(.axi_id_width_p(4), .axi_addr_width_p(32), .axi_data_width_p(32), .axi_len_width_p(8)) axi ();
  bsg_axi_burst_master #(.axi_id_width_p(4), .axi_addr_width_p(32), .axi_data_width_p(32), .axi_len_width_p(8), .axi_id_p(4'h5)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wdata_v_i(wdata_v_i),
    .wdata_ready_o(wdata_ready_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o), .rdata_v_o(rdata_v_o),
    .rdata_ready_i(rdata_ready_i), .done_v_o(done_v_o), .done_err_o(done_err_o), .done_ready_i(done_ready_i), .axi(axi)
  );
  int checks = 0, failures = 0, n_done = 0, tx_beats = 0, slv_delay = 0;
  bit bp = 0, slv_bad_rlast = 0;
  logic [1:0] slv_bresp = OKAY, slv_rresp = OKAY;
  logic [7:0] cur_len = 0;
  logic [31:0] mem [int];
  logic [43:0] exp_aw[$], exp_ar[$];
  logic [32:0] exp_w[$], exp_r[$];
  logic [16:0] exp_done[$];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic slave_idle();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = OKAY; axi.bid = 4'h5;
    axi.arready = 0; axi.rvalid = 0; axi.rresp = OKAY; axi.rlast = 0; axi.rdata = 0; axi.rid = 4'h5;
  endtask
  task automatic slave_write();
    int a, n, beat;
    for (int c = 0; ; c++) begin
      @(posedge clk); #1;
      if (!reset_n) begin slave_idle(); return; end
      axi.awready = c >= slv_delay;
      @(negedge clk);
      if (axi.awvalid && axi.awready) break;
    end
    a = int'(axi.awaddr >> 2); n = int'(axi.awlen); beat = 0;
    while (beat <= n) begin
      @(posedge clk); #1;
      if (!reset_n) begin slave_idle(); return; end
      axi.awready = 0;
      axi.wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (axi.wvalid && axi.wready) begin
        logic [31:0] w;
        w = mem.exists(a + beat) ? mem[a + beat] : 32'h0;
        for (int b = 0; b < 4; b++) if (axi.wstrb[b]) w[8*b +: 8] = axi.wdata[8*b +: 8];
        mem[a + beat] = w;
        beat++;
      end
    end
    for (int c = 0; ; c++) begin
      @(posedge clk); #1;
      if (!reset_n) begin slave_idle(); return; end
      axi.wready = 0; axi.bvalid = c >= slv_delay; axi.bresp = slv_bresp;
      @(negedge clk);
      if (axi.bvalid && axi.bready) break;
    end
    @(posedge clk); #1 axi.bvalid = 0;
  endtask
  task automatic slave_read();
    int a, n, beat;
    bit hs;
    for (int c = 0; ; c++) begin
      @(posedge clk); #1;
      if (!reset_n) begin slave_idle(); return; end
      axi.arready = c >= slv_delay;
      @(negedge clk);
      if (axi.arvalid && axi.arready) break;
    end
    a = int'(axi.araddr >> 2); n = int'(axi.arlen); beat = 0; hs = 0;
    while (beat <= n) begin
      @(posedge clk); #1;
      if (!reset_n) begin slave_idle(); return; end
      axi.arready = 0;
      if (hs) axi.rvalid = 0;
      if (!axi.rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
        axi.rvalid = 1;
        axi.rdata = mem.exists(a + beat) ? mem[a + beat] : 32'hDEAD_BEEF;
        axi.rresp = slv_rresp;
        axi.rlast = beat == n && !slv_bad_rlast;
      end
      @(negedge clk);
      hs = axi.rvalid && axi.rready;
      if (hs) beat++;
    end
    @(posedge clk); #1 axi.rvalid = 0;
  endtask
  initial begin
    slave_idle();
    forever begin
      @(negedge clk);
      if (!reset_n) slave_idle();
      else if (axi.awvalid) slave_write();
      else if (axi.arvalid) slave_read();
    end
  end
  initial forever begin
    @(posedge clk); #1 rdata_ready_i = !bp || $urandom_range(0, 1) == 1;
  end
  // Scoreboard: every observed handshake pops the next expected item
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw_id_addr_len", {axi.awid, axi.awaddr, axi.awlen}, exp_aw.pop_front());
      end
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar_id_addr_len", {axi.arid, axi.araddr, axi.arlen}, exp_ar.pop_front());
      end
      if (axi.wvalid && axi.wready) begin
        tx_beats++;
        check("awlen_hold", axi.awlen, cur_len);
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("w_data_last", {axi.wdata, axi.wlast}, exp_w.pop_front());
      end
      if (rdata_v_o && rdata_ready_i) begin
        tx_beats++;
        check("arlen_hold", axi.arlen, cur_len);
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else check("r_data_last", {rdata_o, rdata_last_o}, exp_r.pop_front());
      end
      if (done_v_o && done_ready_i) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else check("done_err_beats", {done_err_o, 16'(tx_beats)}, exp_done.pop_front());
        tx_beats = 0;
        n_done++;
      end
    end
  end
  task automatic issue(input bit wr, input logic [31:0] addr, input int len);
    @(posedge clk); #1;
    cmd_v_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = 8'(len); cur_len = 8'(len);
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (cmd_ready_o) break;
      if (c > 200) begin check("cmd_accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1 cmd_v_i = 0;
  endtask
  task automatic wait_done(input int d0);
    for (int c = 0; c < 4000 && n_done == d0; c++) @(posedge clk);
    if (n_done == d0) check("done_timeout", 0, 1);
  endtask
  task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] base, input logic exp_err);
    int d0, i, g;
    d0 = n_done;
    exp_aw.push_back({4'h5, addr & ~32'h3, 8'(len)});
    for (int k = 0; k <= len; k++) exp_w.push_back({base + 32'(k), k == len});
    exp_done.push_back({exp_err, 16'(len + 1)});
    issue(1, addr, len);
    i = 0;
    for (g = 0; i <= len && g < 3000; g++) begin
      wdata_v_i = !bp || $urandom_range(0, 1) == 1;
      wdata_i = base + 32'(i);
      @(negedge clk);
      if (wdata_v_i && wdata_ready_o) i++;
      @(posedge clk); #1;
    end
    wdata_v_i = 0;
    if (i <= len) check("wfeed_timeout", 0, 1);
    wait_done(d0);
  endtask
  task automatic start_read(input logic [31:0] addr, input int len, input logic [31:0] base, input logic exp_err, input bit last_ok);
    exp_ar.push_back({4'h5, addr & ~32'h3, 8'(len)});
    for (int k = 0; k <= len; k++) exp_r.push_back({base + 32'(k), k == len && last_ok});
    exp_done.push_back({exp_err, 16'(len + 1)});
    issue(0, addr, len);
  endtask
  task automatic do_read(input logic [31:0] addr, input int len, input logic [31:0] base, input logic exp_err, input bit last_ok);
    int d0;
    d0 = n_done;
    start_read(addr, len, base, exp_err, last_ok);
    wait_done(d0);
  endtask
  initial begin
    #12;
    check("reset_outputs", {cmd_ready_o, wdata_ready_o, rdata_v_o, done_v_o, done_err_o,
                            axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    check("reset_addr_len", {axi.awaddr, axi.awlen}, 0);
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready_o, 1);
    do_write(32'h1003, 3, 32'hA0, 0);
    do_read(32'h1000, 3, 32'hA0, 0, 1);
    do_write(32'h3000, 0, 32'hC0DE_0000, 0);
    do_read(32'h3000, 0, 32'hC0DE_0000, 0, 1);
    bp = 1; slv_delay = 5;
    do_write(32'h4000, 7, 32'hB0, 0);
    do_read(32'h4000, 7, 32'hB0, 0, 1);
    bp = 0; slv_delay = 0;
    slv_bresp = SLVERR;
    do_write(32'h5000, 1, 32'h50, 1);
    slv_bresp = OKAY;
    do_read(32'h5000, 1, 32'h50, 0, 1);
    slv_rresp = DECERR;
    do_read(32'h5000, 1, 32'h50, 1, 1);
    slv_rresp = OKAY; slv_bad_rlast = 1;
    do_read(32'h5000, 1, 32'h50, 1, 0);
    slv_bad_rlast = 0;
    do_write(32'h2000, 7, 32'h20, 0);
    start_read(32'h2000, 7, 32'h20, 0, 1);
    for (int c = 0; c < 500 && tx_beats < 2; c++) @(posedge clk);
    check("reached_beat2", tx_beats, 2);
    #3 reset_n = 0;
    #1;
    check("async_reset_drop", {cmd_ready_o, rdata_v_o, done_v_o, done_err_o, wdata_ready_o,
                               axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    exp_r.delete(); exp_done.delete(); exp_ar.delete(); tx_beats = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("post_reset_idle", {cmd_ready_o, done_v_o, axi.arvalid}, 3'b100);
    do_write(32'h6000, 2, 32'h60, 0);
    do_read(32'h6000, 2, 32'h60, 0, 1);
    do_write(32'h8000, 255, 32'h1000_0000, 0);
    do_read(32'h8000, 255, 32'h1000_0000, 0, 1);
    check("scoreboard_drained", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
